// File: rtl/isqrt_pkg.sv
// Shared types and the single-iteration function for the pipelined integer square root.
// Holds widths, the per-stage bank layout, and one digit-by-digit root iteration.
// Used by the isqrt_step datapath.
package isqrt_pkg;

    localparam int ISQRT_X_W   = 32;
    localparam int ISQRT_Y_W   = 16;
    localparam int ISQRT_REM_W = 19;

    // One pipeline bank: valid flag, radicand bits still to consume (top-aligned),
    // partial remainder and partial root.
    typedef struct packed {
        logic                   vld;
        logic [ISQRT_X_W-1:0]   xrem;
        logic [ISQRT_REM_W-1:0] rem;
        logic [ISQRT_Y_W-1:0]   root;
    } isqrt_stage_t;

    // One root bit: bring down the next two radicand bits, then try to subtract
    // (root << 2) | 1. The radicand is shifted left so the next pair always sits
    // at the top, letting every stage read the same fixed slice.
    function automatic isqrt_stage_t isqrt_iter(input isqrt_stage_t s);
        isqrt_stage_t           o;
        logic [ISQRT_REM_W-1:0] r;
        logic [ISQRT_REM_W-1:0] t;
        r = (s.rem << 2) | {{(ISQRT_REM_W-2){1'b0}}, s.xrem[ISQRT_X_W-1 -: 2]};
        t = {1'b0, s.root, 2'b01};
        o.vld  = s.vld;
        o.xrem = s.xrem << 2;
        if (r >= t) begin
            o.rem  = r - t;
            o.root = (s.root << 1) | {{(ISQRT_Y_W-1){1'b0}}, 1'b1};
        end else begin
            o.rem  = r;
            o.root = s.root << 1;
        end
        return o;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One combinational root-bit iteration of the integer square root.
// Ports: in_* is the incoming stage state (vld, xrem, rem, root); out_* is the
// state after resolving one more root bit. Pure combinational, no clock.
module isqrt_step
    import isqrt_pkg::*;
(
    input  logic                   in_vld,
    input  logic [ISQRT_X_W-1:0]   in_xrem,
    input  logic [ISQRT_REM_W-1:0] in_rem,
    input  logic [ISQRT_Y_W-1:0]   in_root,
    output logic                   out_vld,
    output logic [ISQRT_X_W-1:0]   out_xrem,
    output logic [ISQRT_REM_W-1:0] out_rem,
    output logic [ISQRT_Y_W-1:0]   out_root
);

    isqrt_stage_t s_in;
    isqrt_stage_t s_out;

    assign s_in  = {in_vld, in_xrem, in_rem, in_root};
    assign s_out = isqrt_iter(s_in);

    assign out_vld  = s_out.vld;
    assign out_xrem = s_out.xrem;
    assign out_rem  = s_out.rem;
    assign out_root = s_out.root;

endmodule

// File: rtl/isqrt_pipe.sv
// Pipelined y = floor(sqrt(x)), 32-bit x to 16-bit y, one operand per cycle.
// Latency 16/REG_EVERY cycles; no backpressure, results in order.
// Ports: clk, rst (sync, active-high), x_vld/x in, y_vld/y out (y valid only with y_vld).
module isqrt_pipe
    import isqrt_pkg::*;
#(
    parameter int REG_EVERY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  logic [ISQRT_X_W-1:0] x,
    output logic                 y_vld,
    output logic [ISQRT_Y_W-1:0] y
);

    localparam int NITER  = ISQRT_Y_W;
    localparam int NSTAGE = NITER / REG_EVERY;

    if (REG_EVERY < 1 || REG_EVERY > NITER || (NITER % REG_EVERY) != 0) begin : g_bad_param
        $error("isqrt_pipe: REG_EVERY must divide 16");
    end

    isqrt_stage_t step_in  [NITER];
    isqrt_stage_t step_out [NITER];
    isqrt_stage_t pipe_q   [NSTAGE];

    for (genvar k = 0; k < NITER; k++) begin : g_step
        if (k == 0) begin : g_first
            assign step_in[k] = {x_vld, x, {ISQRT_REM_W{1'b0}}, {ISQRT_Y_W{1'b0}}};
        end else if ((k % REG_EVERY) == 0) begin : g_from_reg
            assign step_in[k] = pipe_q[k/REG_EVERY - 1];
        end else begin : g_chain
            assign step_in[k] = step_out[k-1];
        end

        isqrt_step u_step (
            .in_vld  (step_in[k].vld),
            .in_xrem (step_in[k].xrem),
            .in_rem  (step_in[k].rem),
            .in_root (step_in[k].root),
            .out_vld (step_out[k].vld),
            .out_xrem(step_out[k].xrem),
            .out_rem (step_out[k].rem),
            .out_root(step_out[k].root)
        );
    end

    // Only the valid chain is reset; data banks free-run and may hold stale
    // values behind a cleared valid. Reset also drops an operand on the same edge.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NSTAGE; j++) begin
            pipe_q[j] <= step_out[(j+1)*REG_EVERY - 1];
            if (rst) begin
                pipe_q[j].vld <= 1'b0;
            end
        end
    end

    assign y_vld = pipe_q[NSTAGE-1].vld;
    assign y     = pipe_q[NSTAGE-1].root;

    // Final remainder and exhausted radicand bits are intentionally dropped.
    logic unused_tail;
    assign unused_tail = ^{pipe_q[NSTAGE-1].rem, pipe_q[NSTAGE-1].xrem};

endmodule

// File: doc/isqrt_pipe.md
# isqrt_pipe

Pipelined unsigned integer square root: y = floor(sqrt(x)) for a 32-bit x, producing a 16-bit y. It sits directly downstream of the formula FSMs and is their single shared isqrt instance. It consumes `isqrt_x_vld`/`isqrt_x` and returns `isqrt_y_vld`/`isqrt_y`. It accepts one operand per cycle with a fixed, parameter-defined latency, has no backpressure, and keeps results in order.

## Interface
- `REG_EVERY`, default 1: number of root-bit iterations per pipeline register. Legal values are 1, 2, 4, 8, 16. Latency L = 16 / REG_EVERY cycles.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high; clock clk.
- `x_vld` in 1: operand valid. The operand is accepted on every rising edge where it is high.
- `x` in 32: unsigned radicand.
- `y_vld` out 1: result valid. It is a single-cycle pulse per accepted operand.
- `y` out 16: floor(sqrt(x)). Meaningful only while `y_vld` is 1.

## Operation
- **Algorithm:** digit-by-digit binary root, 16 iterations, i = 15 down to 0. Start with rem = 0 and root = 0. Each iteration:
  - rem = (rem << 2) | x[2i+1:2i]
  - trial = (root << 2) | 1
  - If rem >= trial: rem = rem − trial and root = (root << 1) | 1.
  - Otherwise: root = root << 1.
- **Widths:**
  - rem is 19 bits, since rem ≤ 2·root before the shift.
  - trial is 19 bits, zero-extended.
  - root is 16 bits.
  - The compare and subtract are unsigned. No overflow is possible.
- **Per pipeline stage:**
  - A stage holds REG_EVERY iterations of combinational logic, then a register bank.
  - The bank holds: valid bit, remaining unconsumed radicand bits, rem, and root.
  - The radicand bits may be shifted left 2·REG_EVERY bits per stage, so each stage reads a fixed top slice.
- **Final result:** `y` is the final root register. The final rem is discarded.
- **Throughput and ordering:** one operand per cycle. Operands are fully independent. There is no stall, no flush and no backpressure. Output order equals input order.
- **Bubbles:** bubbles (`x_vld` = 0) propagate as valid = 0. Data registers may still clock with stale data.
- **Stateless per transaction:** there is no FSM. The only state is the valid shift chain plus the data pipeline.

## Timing
- **Reset:**
  - All valid bits clear to 0, so `y_vld` = 0 from the first cycle after reset.
  - Data registers are not reset. `y` is don't-care while `y_vld` = 0.
- **Latency:** x sampled at edge n gives `y_vld` = 1 with the result after edge n + L. With default L = 16; with REG_EVERY = 16, L = 1.
- **No combinational path** from `x`/`x_vld` to `y`/`y_vld`.
- **Reset mid-operation:** every in-flight operand is dropped. No `y_vld` pulse appears for operands accepted before the reset edge.
- **Same edge as reset:** an operand presented on the same edge as `rst` = 1 is dropped.
- **Back-to-back input:** N consecutive `x_vld` cycles produce N consecutive `y_vld` cycles, L cycles later.
- **Boundaries:**
  - x = 0 gives 0.
  - x = 0xFFFFFFFF gives 0xFFFF.
  - Perfect squares are exact.
  - x = k² − 1 gives k − 1.
- **Upstream compatibility:** the formula FSM issues its next operand in the same cycle it sees `y_vld`. The block must accept that operand with no dead cycle.

## Structure
- **Shared package `isqrt_pkg`:**
  - `ISQRT_X_W` = 32, `ISQRT_Y_W` = 16, `ISQRT_REM_W` = 19.
  - A packed struct `isqrt_stage_t` {vld, xrem, rem, root}.
  - A function computing one iteration, reused by the sub-module and the bench model.
- **Sub-module `isqrt_step`:** combinational, performs one iteration. The top generates 16 instances and inserts registers after every REG_EVERY-th instance.
- **Parameter check:** the top fails elaboration when 16 % REG_EVERY ≠ 0.

## Test plan
- **Single operands (default L = 16):**
  - Pulse `x_vld` with x = 0 → after 16 cycles `y_vld` = 1, `y` = 0. No other `y_vld` pulse occurs.
  - x = 0xFFFFFFFF → `y` = 0xFFFF.
  - x = 16 → 4; x = 15 → 3; x = 0x40000000 → 0x8000.
- **Streaming:** x = 0, 1, 2, 3, 4, 8, 9 on 7 consecutive cycles → `y` = 0, 1, 1, 1, 2, 2, 3 on 7 consecutive cycles, starting 16 cycles after the first.
- **Gapped input:** `x_vld` pattern 1, 0, 1 with x = 100, –, 99 → `y_vld` pattern 1, 0, 1 with y = 10, 9.
- **Reset mid-flight:** issue x = 25 at cycle 0, assert `rst` at cycle 5 → `y_vld` stays 0 through cycle 20. Then x = 25 → y = 5 after 16 cycles.
- **REG_EVERY = 4 and 16:**
  - x = 1000000 → y = 1000 at latency 4 and 1 respectively.
  - Integrated with `formula_2_fsm`, a = 1, b = 4, c = 16 → isqrt(16) = 4, isqrt(8) = 2, isqrt(3) = 1, so res = 1.
